// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths, PPROT bit layout and the initiator FSM states.
package apb_pkg;

  localparam int APB_AW = 32;
  localparam int APB_DW = 32;
  localparam int APB_SW = APB_DW / 8;

  // PPROT[0]=privileged, PPROT[1]=non-secure, PPROT[2]=instruction
  typedef struct packed {
    logic instr;
    logic nonsec;
    logic priv;
  } pprot_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } apb_state_e;

endpackage

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB initiator: valid/ready command in, APB SETUP/ACCESS transfer
// out, captured read data / error / wait count returned on a valid/ready response.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int WAIT_W = 8
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [APB_AW-1:0] req_addr,
  input  logic [APB_DW-1:0] req_wdata,
  input  logic [APB_SW-1:0] req_strb,
  input  logic [2:0]        req_prot,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [APB_DW-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [WAIT_W-1:0] rsp_wait,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [APB_AW-1:0] PADDR,
  output logic [APB_DW-1:0] PWDATA,
  output logic [APB_SW-1:0] PSTRB,
  output logic [2:0]        PPROT,
  input  logic [APB_DW-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

  apb_state_e        state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [APB_DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [WAIT_W-1:0] rsp_wait_q, rsp_wait_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [APB_AW-1:0] paddr_q, paddr_d;
  logic [APB_DW-1:0] pwdata_q, pwdata_d;
  logic [APB_SW-1:0] pstrb_q, pstrb_d;
  pprot_t            pprot_q, pprot_d;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_wait_q  <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      pprot_q     <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_wait_q  <= rsp_wait_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      pprot_q     <= pprot_d;
    end
  end

  // Every output is a flop, so each branch sets the value the bus shows next cycle.
  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_wait_d  = rsp_wait_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    pprot_d     = pprot_q;

    case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          state_d     = ST_SETUP;
          req_ready_d = 1'b0;
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          pwrite_d    = req_write;
          paddr_d     = req_addr;
          pprot_d     = pprot_t'(req_prot);
          pwdata_d    = req_write ? req_wdata : '0;
          pstrb_d     = req_write ? req_strb : '0;
          rsp_wait_d  = '0;
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        if (PREADY) begin
          state_d     = ST_RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          pstrb_d     = '0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
          rsp_err_d   = PSLVERR;
        end else if (rsp_wait_q != WAIT_MAX) begin
          rsp_wait_d = rsp_wait_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_wait  = rsp_wait_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PSTRB     = pstrb_q;
  assign PPROT     = pprot_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: a small wait-state/error-capable APB memory completer
// plus a transaction-level memory model that predicts every response.
module tb_apb_master_bridge;

  localparam int WAIT_W   = 8;
  localparam int WAIT_MAX = (1 << WAIT_W) - 1;

  logic              PCLK = 1'b0;
  logic              PRESETn = 1'b0;
  logic              req_valid, req_ready, req_write;
  logic [31:0]       req_addr, req_wdata;
  logic [3:0]        req_strb;
  logic [2:0]        req_prot;
  logic              rsp_valid, rsp_ready, rsp_err;
  logic [31:0]       rsp_rdata;
  logic [WAIT_W-1:0] rsp_wait;
  logic              PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [31:0]       PADDR, PWDATA, PRDATA;
  logic [3:0]        PSTRB;
  logic [2:0]        PPROT;

  int vector_count = 0;
  int miss_count   = 0;

  always #5 PCLK = ~PCLK;

  apb_master_bridge #(.WAIT_W(WAIT_W)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_wait(rsp_wait),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  // Completer: 16-word memory, programmable wait states and error behaviour.
  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];
  bit          mem_loaded = 1'b0;
  int          cfg_waits = 0;
  bit          cfg_err = 1'b0;
  bit          cfg_err_in_wait = 1'b0;
  int          acc_cnt;
  logic        access_phase;

  function automatic logic [31:0] mem_init(input int i);
    return (32'h9E37_79B9 * (i + 1)) ^ 32'h5A5A_0F0F;
  endfunction

  assign access_phase = PSEL & PENABLE;
  assign PREADY  = access_phase && (acc_cnt >= cfg_waits);
  assign PSLVERR = access_phase && (PREADY ? cfg_err : cfg_err_in_wait);
  assign PRDATA  = PREADY ? mem[PADDR[5:2]] : (32'hA5A5_0000 ^ 32'(acc_cnt));

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      acc_cnt <= 0;
      if (!mem_loaded) begin
        for (int i = 0; i < 16; i++) mem[i] <= mem_init(i);
        mem_loaded <= 1'b1;
      end
    end else begin
      if (access_phase && !PREADY) acc_cnt <= acc_cnt + 1;
      else acc_cnt <= 0;
      if (access_phase && PREADY && PWRITE)
        for (int b = 0; b < 4; b++)
          if (PSTRB[b]) mem[PADDR[5:2]][8*b +: 8] <= PWDATA[8*b +: 8];
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vector_count++;
    if (got !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic scrambleInputs();
    req_valid = 1'($urandom);
    req_write = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_strb  = 4'($urandom);
    req_prot  = 3'($urandom);
  endtask

  // One full transfer; called at a negedge, returns at a negedge with the DUT in IDLE.
  task automatic applyStimulus(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] strb, input logic [2:0] prot, input int waits,
                               input bit err, input bit err_in_wait, input int hold);
    int          idx;
    int          guard;
    int          psel_cycles;
    int          pen_cycles;
    logic [31:0] exp_rdata;
    logic [WAIT_W-1:0] exp_wait;
    logic [71:0] exp_bus;

    idx = int'(addr[5:2]);
    exp_rdata = wr ? 32'h0 : ref_mem[idx];
    if (wr)
      for (int b = 0; b < 4; b++)
        if (strb[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
    exp_wait = (waits > WAIT_MAX) ? WAIT_W'(WAIT_MAX) : WAIT_W'(waits);
    exp_bus  = {addr, wr, (wr ? wdata : 32'h0), (wr ? strb : 4'h0), prot};

    cfg_waits = waits;
    cfg_err = err;
    cfg_err_in_wait = err_in_wait;
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_strb  = strb;
    req_prot  = prot;

    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge PCLK);
      guard++;
    end
    checkOutput("accept_timeout", 128'(guard < 20), 128'd1);
    if (guard >= 20) begin
      req_valid = 1'b0;
      return;
    end

    @(negedge PCLK);
    checkOutput("setup_phase", {PSEL, PENABLE, req_ready, rsp_valid}, 4'b1000);
    psel_cycles = 0;
    pen_cycles  = 0;
    guard = 0;
    while (!rsp_valid && guard < 1000) begin
      if (PSEL) psel_cycles++;
      if (PENABLE) pen_cycles++;
      checkOutput("bus_stable", {PADDR, PWRITE, PWDATA, PSTRB, PPROT}, exp_bus);
      scrambleInputs();
      rsp_ready = 1'($urandom);
      @(negedge PCLK);
      guard++;
    end
    checkOutput("rsp_timeout", 128'(guard < 1000), 128'd1);
    req_valid = 1'b0;
    rsp_ready = 1'b0;

    checkOutput("psel_cycles", psel_cycles, waits + 2);
    checkOutput("penable_cycles", pen_cycles, waits + 1);
    checkOutput("resp_bus_idle", {PSEL, PENABLE, PSTRB, req_ready}, 7'b0);
    checkOutput("resp_bus_held", {PADDR, PWRITE, PPROT}, {addr, wr, prot});
    checkOutput("rsp_rdata", rsp_rdata, exp_rdata);
    checkOutput("rsp_err", rsp_err, err);
    checkOutput("rsp_wait", rsp_wait, exp_wait);

    for (int c = 0; c < hold; c++) begin
      scrambleInputs();
      req_valid = 1'b1;
      @(negedge PCLK);
      checkOutput("hold_state", {rsp_valid, req_ready, PSEL, PENABLE}, 4'b1000);
      checkOutput("hold_rsp", {rsp_rdata, rsp_err, rsp_wait}, {exp_rdata, err, exp_wait});
    end

    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge PCLK);
    rsp_ready = 1'b0;
    checkOutput("rsp_done", {rsp_valid, req_ready, PSEL}, 3'b010);
  endtask

  // Write stalled in ACCESS, then reset pulled asynchronously; the write must not land.
  task automatic resetMidTransfer();
    cfg_waits = 20;
    cfg_err = 1'b0;
    cfg_err_in_wait = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h0000_0008;
    req_wdata = 32'hCAFE_F00D;
    req_strb  = 4'hF;
    req_prot  = 3'b101;
    @(negedge PCLK);
    req_valid = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    checkOutput("pre_reset_access", {PSEL, PENABLE}, 2'b11);
    #2 PRESETn = 1'b0;
    #1;
    checkOutput("async_reset_outputs",
                {req_ready, rsp_valid, PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT},
                75'b0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    #1 checkOutput("ready_after_release", req_ready, 1'b0);
    @(negedge PCLK);
    checkOutput("idle_after_reset", {req_ready, rsp_valid, PSEL, rsp_wait}, {1'b1, 1'b0, 1'b0, 8'h0});
  endtask

  initial begin
    bit   wr;
    logic [31:0] addr;

    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_strb  = '0;
    req_prot  = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = mem_init(i);

    repeat (3) @(negedge PCLK);
    checkOutput("reset_state",
                {req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_wait, PSEL, PENABLE,
                 PWRITE, PADDR, PWDATA, PSTRB, PPROT}, 117'b0);
    PRESETn = 1'b1;
    #1 checkOutput("ready_first_cycle", req_ready, 1'b0);
    @(negedge PCLK);
    checkOutput("ready_after_reset", req_ready, 1'b1);

    applyStimulus(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 3'b000, 0, 1'b0, 1'b0, 0);
    applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, 3'b001, 3, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 32'h20, 32'hFFFF_FFFF, 4'hF, 3'b010, 1, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 32'h20, 32'h1234_5678, 4'h3, 3'b011, 0, 1'b0, 1'b0, 0);
    applyStimulus(1'b0, 32'h20, 32'h5555_5555, 4'hF, 3'b100, 2, 1'b0, 1'b0, 0);
    applyStimulus(1'b0, 32'h30, 32'h0, 4'h0, 3'b000, 2, 1'b1, 1'b0, 0);
    applyStimulus(1'b1, 32'h34, 32'h0BAD_0BAD, 4'hC, 3'b000, 0, 1'b1, 1'b1, 0);
    applyStimulus(1'b0, 32'h34, 32'h0, 4'h0, 3'b000, 4, 1'b0, 1'b1, 0);
    applyStimulus(1'b1, 32'h3C, 32'h8765_4321, 4'h5, 3'b111, 1, 1'b0, 1'b0, 5);
    applyStimulus(1'b0, 32'h3C, 32'h0, 4'h0, 3'b110, 0, 1'b0, 1'b0, 0);
    applyStimulus(1'b0, 32'h1000_0004, 32'h0, 4'h0, 3'b000, 300, 1'b0, 1'b0, 1);

    resetMidTransfer();
    applyStimulus(1'b0, 32'h08, 32'h0, 4'h0, 3'b000, 0, 1'b0, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      wr   = 1'($urandom);
      addr = {26'($urandom), 4'($urandom), 2'b00};
      applyStimulus(wr, addr, $urandom, 4'($urandom), 3'($urandom),
                    $urandom_range(0, 6), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 2) == 0), $urandom_range(0, 3));
    end

    for (int i = 0; i < 16; i++)
      applyStimulus(1'b0, 32'(i * 4), 32'h0, 4'h0, 3'b000, 0, 1'b0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
    $finish;
  end

endmodule
